// File: rtl/sp_ram_pkg.sv
// Shared types and helpers for the single-port RAM responder.
// Optional parity storage is enabled with `define RAM_PARITY_EN.
`ifndef ADDR_WIDTH
`define ADDR_WIDTH 12
`endif
`ifndef DATA_WIDTH
`define DATA_WIDTH 16
`endif

package sp_ram_pkg;

  typedef enum logic {
    INIT = 1'b0,
    RUN  = 1'b1
  } state_e;

  localparam int LAT_MIN = 1;
  localparam int LAT_MAX = 2;

`ifdef RAM_PARITY_EN
  localparam int PAR_W = 1;
`else
  localparam int PAR_W = 0;
`endif

  localparam int DW     = `DATA_WIDTH;
  localparam int WORD_W = DW + PAR_W;

  // Even parity: the returned bit makes the total count of ones even.
  function automatic logic parity(input logic [DW-1:0] d);
    return ^d;
  endfunction

endpackage

// File: rtl/single_port_ram_intf.sv
// Request/response bundle between a compute unit and its local RAM.
// The compute side drives requests; the memory side returns R_data.
`ifndef ADDR_WIDTH
`define ADDR_WIDTH 12
`endif
`ifndef DATA_WIDTH
`define DATA_WIDTH 16
`endif

interface single_port_ram_intf;
  logic                   cs;
  logic                   oe;
  logic [`ADDR_WIDTH-1:0] addr;
  logic                   W_req;
  logic [`DATA_WIDTH-1:0] W_data;
  logic [`DATA_WIDTH-1:0] R_data;

  modport memory (
    input  cs, oe, addr, W_req, W_data,
    output R_data
  );

  modport compute (
    output cs, oe, addr, W_req, W_data,
    input  R_data
  );
endinterface

// File: rtl/sp_ram_array.sv
// Storage array with one shared address, a write port and a
// registered one-cycle read port.
module sp_ram_array #(
  parameter int DEPTH = 1024,
  parameter int W     = 16,
  parameter int AW    = 10
) (
  input  logic          clk,
  input  logic          we_i,
  input  logic          re_i,
  input  logic [AW-1:0] addr_i,
  input  logic [W-1:0]  wdata_i,
  output logic [W-1:0]  rdata_o
);

  logic [W-1:0] mem_q [DEPTH];
  logic [W-1:0] rdata_q;

  always_ff @(posedge clk) begin
    if (we_i) mem_q[addr_i] <= wdata_i;
    if (re_i) rdata_q <= mem_q[addr_i];
  end

  assign rdata_o = rdata_q;

endmodule

// File: rtl/sp_ram_responder.sv
// Memory-side responder: zero-fill FSM, request decode, read latency
// pipeline and error flags. Parity checking under `RAM_PARITY_EN.
module sp_ram_responder
  import sp_ram_pkg::*;
#(
  parameter int DEPTH    = 1024,
  parameter int READ_LAT = 1
) (
  input  logic                      clk,
  input  logic                      rst_n,
  single_port_ram_intf.memory       mem,
  output logic                      ready,
  output logic                      addr_err,
  input  logic                      err_clr,
  output logic                      par_err
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  if (READ_LAT < LAT_MIN || READ_LAT > LAT_MAX) begin : g_bad_lat
    $error("sp_ram_responder: READ_LAT must be 1 or 2");
  end
  if (DEPTH > (1 << `ADDR_WIDTH)) begin : g_bad_depth
    $error("sp_ram_responder: DEPTH exceeds address space");
  end

  state_e        state_q;
  logic [AW-1:0] init_cnt_q;
  logic          ready_q;
  logic          addr_err_q;
  logic          par_err_q;
  logic [DW-1:0] r_data_q;

  logic          s1_v_q;
  logic          s1_oe_q;
  logic          s1_oor_q;

  logic          run;
  logic          req;
  logic          oor;
  logic          wr;
  logic          rd;

  logic          arr_we;
  logic          arr_re;
  logic [AW-1:0] arr_addr;
  logic [WORD_W-1:0] arr_wdata;
  logic [WORD_W-1:0] arr_rdata;
  logic [WORD_W-1:0] word_in;

  logic              ret_v;
  logic              ret_oe;
  logic              ret_oor;
  logic [WORD_W-1:0] ret_word;
  logic [DW-1:0]     ret_data;
  logic              par_bad;

  assign run = (state_q == RUN);
  assign req = run & mem.cs;
  assign oor = 32'(mem.addr) >= DEPTH;
  assign wr  = req & mem.W_req & ~oor;
  assign rd  = req & ~mem.W_req;

`ifdef RAM_PARITY_EN
  assign word_in = {parity(mem.W_data), mem.W_data};
`else
  assign word_in = mem.W_data;
`endif

  // INIT owns the array port; zeros include the parity bit.
  assign arr_we    = ~run | wr;
  assign arr_re    = rd & ~oor;
  assign arr_addr  = run ? mem.addr[AW-1:0] : init_cnt_q;
  assign arr_wdata = run ? word_in : '0;

  sp_ram_array #(
    .DEPTH (DEPTH),
    .W     (WORD_W),
    .AW    (AW)
  ) u_array (
    .clk     (clk),
    .we_i    (arr_we),
    .re_i    (arr_re),
    .addr_i  (arr_addr),
    .wdata_i (arr_wdata),
    .rdata_o (arr_rdata)
  );

  if (READ_LAT == 2) begin : g_lat2
    logic              s2_v_q;
    logic              s2_oe_q;
    logic              s2_oor_q;
    logic [WORD_W-1:0] s2_word_q;

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        s2_v_q    <= 1'b0;
        s2_oe_q   <= 1'b0;
        s2_oor_q  <= 1'b0;
        s2_word_q <= '0;
      end else begin
        s2_v_q    <= s1_v_q;
        s2_oe_q   <= s1_oe_q;
        s2_oor_q  <= s1_oor_q;
        s2_word_q <= arr_rdata;
      end
    end

    assign ret_v    = s2_v_q;
    assign ret_oe   = s2_oe_q;
    assign ret_oor  = s2_oor_q;
    assign ret_word = s2_word_q;
  end else begin : g_lat1
    assign ret_v    = s1_v_q;
    assign ret_oe   = s1_oe_q;
    assign ret_oor  = s1_oor_q;
    assign ret_word = arr_rdata;
  end

  assign ret_data = ret_oor ? '0 : ret_word[DW-1:0];

`ifdef RAM_PARITY_EN
  assign par_bad = ret_v & ~ret_oor &
                   (parity(ret_word[DW-1:0]) != ret_word[DW]);
`else
  assign par_bad = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= INIT;
      init_cnt_q <= '0;
      ready_q    <= 1'b0;
      addr_err_q <= 1'b0;
      par_err_q  <= 1'b0;
      r_data_q   <= '0;
      s1_v_q     <= 1'b0;
      s1_oe_q    <= 1'b0;
      s1_oor_q   <= 1'b0;
    end else begin
      unique case (state_q)
        INIT: begin
          init_cnt_q <= init_cnt_q + 1'b1;
          if (init_cnt_q == AW'(DEPTH - 1)) begin
            state_q <= RUN;
            ready_q <= 1'b1;
          end
        end
        RUN: ;
        default: state_q <= INIT;
      endcase

      s1_v_q   <= rd;
      s1_oe_q  <= mem.oe;
      s1_oor_q <= oor;

      if (ret_v && ret_oe) r_data_q <= ret_data;
      par_err_q <= par_bad;

      // A new error beats a concurrent clear.
      if (req && oor)   addr_err_q <= 1'b1;
      else if (err_clr) addr_err_q <= 1'b0;
    end
  end

  assign mem.R_data = r_data_q;
  assign ready      = ready_q;
  assign addr_err   = addr_err_q;
  assign par_err    = par_err_q;

endmodule

// File: tb/tb_sp_ram_responder.sv
// Directed bench for sp_ram_responder (DEPTH=16).
// Build with +define+RAM_PARITY_EN to exercise the parity path.
`ifndef ADDR_WIDTH
`define ADDR_WIDTH 12
`endif
`ifndef DATA_WIDTH
`define DATA_WIDTH 16
`endif

module tb_sp_ram_responder;

  localparam int DEPTH = 16;
  localparam int LAT   = 1;

  logic clk;
  logic rst_n;
  logic ready;
  logic addr_err;
  logic err_clr;
  logic par_err;

  int pass_cnt = 0;
  int total_cnt = 0;

  single_port_ram_intf ram_if ();

  sp_ram_responder #(
    .DEPTH    (DEPTH),
    .READ_LAT (LAT)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .mem      (ram_if),
    .ready    (ready),
    .addr_err (addr_err),
    .err_clr  (err_clr),
    .par_err  (par_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        cs;
    logic        w;
    logic        oe;
    logic        clr;
    logic [11:0] addr;
    logic [15:0] wd;
    logic [15:0] exp_r;
    logic        exp_err;
  } vec_t;

  vec_t vecs [22];

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    total_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  task automatic idle();
    ram_if.cs     = 1'b0;
    ram_if.W_req  = 1'b0;
    ram_if.oe     = 1'b0;
    ram_if.addr   = '0;
    ram_if.W_data = '0;
    err_clr       = 1'b0;
  endtask

  task automatic op(input logic cs, input logic w, input logic oe,
                    input logic clr, input logic [11:0] a,
                    input logic [15:0] d);
    ram_if.cs     = cs;
    ram_if.W_req  = w;
    ram_if.oe     = oe;
    ram_if.addr   = a;
    ram_if.W_data = d;
    err_clr       = clr;
    @(posedge clk);
    @(negedge clk);
    idle();
  endtask

  task automatic wait_lat();
    repeat (LAT) @(posedge clk);
    @(negedge clk);
  endtask

  task automatic reset_checks(input string tag);
    chk({tag, "_rdata"}, 32'(ram_if.R_data), 32'h0);
    chk({tag, "_ready"}, 32'(ready), 32'h0);
    chk({tag, "_addr_err"}, 32'(addr_err), 32'h0);
    chk({tag, "_par_err"}, 32'(par_err), 32'h0);
  endtask

  // Releases reset at a negedge and counts cycles until ready,
  // optionally hammering the port with requests that must be ignored.
  task automatic fill(input string tag, input bit drive);
    int n;
    n = 0;
    rst_n = 1'b1;
    while (!ready && n < 100) begin
      if (drive) begin
        ram_if.cs     = 1'b1;
        ram_if.W_req  = n[0] ? 1'b0 : 1'b1;
        ram_if.oe     = 1'b1;
        ram_if.addr   = n[0] ? 12'd20 : 12'd2;
        ram_if.W_data = 16'hFFFF;
      end
      @(posedge clk);
      @(negedge clk);
      n++;
    end
    idle();
    chk({tag, "_fill_cycles"}, 32'(n), 32'(DEPTH));
    chk({tag, "_no_err_in_init"}, 32'(addr_err), 32'h0);
  endtask

  initial begin
    logic [11:0] b2b_a [3];
    logic [15:0] b2b_d [3];

    vecs = '{
      '{1'b1, 1'b1, 1'b0, 1'b0, 12'd3,  16'hA5A5, 16'h0000, 1'b0},
      '{1'b1, 1'b0, 1'b1, 1'b0, 12'd3,  16'h0000, 16'hA5A5, 1'b0},
      '{1'b1, 1'b1, 1'b0, 1'b0, 12'd4,  16'h1111, 16'hA5A5, 1'b0},
      '{1'b1, 1'b0, 1'b0, 1'b0, 12'd4,  16'h0000, 16'hA5A5, 1'b0},
      '{1'b1, 1'b0, 1'b1, 1'b0, 12'd4,  16'h0000, 16'h1111, 1'b0},
      '{1'b1, 1'b0, 1'b1, 1'b0, 12'd5,  16'h0000, 16'h0000, 1'b0},
      '{1'b1, 1'b0, 1'b1, 1'b0, 12'd3,  16'h0000, 16'hA5A5, 1'b0},
      '{1'b1, 1'b1, 1'b0, 1'b0, 12'd16, 16'hFFFF, 16'hA5A5, 1'b1},
      '{1'b1, 1'b0, 1'b1, 1'b0, 12'd16, 16'h0000, 16'h0000, 1'b1},
      '{1'b0, 1'b0, 1'b0, 1'b1, 12'd0,  16'h0000, 16'h0000, 1'b0},
      '{1'b1, 1'b0, 1'b1, 1'b0, 12'd3,  16'h0000, 16'hA5A5, 1'b0},
      '{1'b1, 1'b0, 1'b1, 1'b0, 12'd0,  16'h0000, 16'h0000, 1'b0},
      '{1'b1, 1'b0, 1'b1, 1'b1, 12'd17, 16'h0000, 16'h0000, 1'b1},
      '{1'b0, 1'b0, 1'b0, 1'b1, 12'd0,  16'h0000, 16'h0000, 1'b0},
      '{1'b0, 1'b1, 1'b0, 1'b0, 12'd7,  16'hBEEF, 16'h0000, 1'b0},
      '{1'b1, 1'b0, 1'b1, 1'b0, 12'd3,  16'h0000, 16'hA5A5, 1'b0},
      '{1'b1, 1'b0, 1'b1, 1'b0, 12'd7,  16'h0000, 16'h0000, 1'b0},
      '{1'b1, 1'b1, 1'b0, 1'b0, 12'd15, 16'h1234, 16'h0000, 1'b0},
      '{1'b1, 1'b0, 1'b1, 1'b0, 12'd15, 16'h0000, 16'h1234, 1'b0},
      '{1'b0, 1'b0, 1'b1, 1'b0, 12'd3,  16'h0000, 16'h1234, 1'b0},
      '{1'b1, 1'b1, 1'b1, 1'b0, 12'd5,  16'h2222, 16'h1234, 1'b0},
      '{1'b1, 1'b0, 1'b1, 1'b0, 12'd5,  16'h0000, 16'h2222, 1'b0}
    };

    rst_n = 1'b0;
    idle();
    #1;
    reset_checks("por");
    repeat (2) @(negedge clk);

    fill("por", 1'b1);
    for (int i = 0; i < DEPTH; i++) begin
      op(1'b1, 1'b0, 1'b1, 1'b0, 12'(i), 16'h0);
      wait_lat();
      chk($sformatf("zero_fill[%0d]", i), 32'(ram_if.R_data), 32'h0);
    end

    for (int i = 0; i < 22; i++) begin
      op(vecs[i].cs, vecs[i].w, vecs[i].oe, vecs[i].clr,
         vecs[i].addr, vecs[i].wd);
      chk($sformatf("vec%0d_addr_err", i), 32'(addr_err),
          32'(vecs[i].exp_err));
      wait_lat();
      chk($sformatf("vec%0d_rdata", i), 32'(ram_if.R_data),
          32'(vecs[i].exp_r));
    end

    // Write then read the same word on the very next cycle.
    op(1'b1, 1'b1, 1'b0, 1'b0, 12'd3, 16'h5A5A);
    op(1'b1, 1'b0, 1'b1, 1'b0, 12'd3, 16'h0);
    if (LAT > 1) chk("raw_not_early", 32'(ram_if.R_data), 32'h2222);
    repeat (LAT - 1) @(posedge clk);
    if (LAT > 1) @(negedge clk);
    chk("raw_before_lat", 32'(ram_if.R_data), 32'h2222);
    @(posedge clk);
    @(negedge clk);
    chk("raw_new_data", 32'(ram_if.R_data), 32'h5A5A);

    // Three back-to-back reads, one result per cycle.
    b2b_a = '{12'd3, 12'd4, 12'd15};
    b2b_d = '{16'h5A5A, 16'h1111, 16'h1234};
    for (int k = 0; k <= LAT + 3; k++) begin
      if (k >= LAT + 1 && k - LAT - 1 < 3)
        chk($sformatf("b2b%0d", k - LAT - 1), 32'(ram_if.R_data),
            32'(b2b_d[k - LAT - 1]));
      if (k < 3) begin
        ram_if.cs   = 1'b1;
        ram_if.oe   = 1'b1;
        ram_if.addr = b2b_a[k];
      end else begin
        idle();
      end
      @(posedge clk);
      @(negedge clk);
    end

`ifdef RAM_PARITY_EN
    op(1'b1, 1'b1, 1'b0, 1'b0, 12'd3, 16'h0003);
    dut.u_array.mem_q[3][`DATA_WIDTH] = ~dut.u_array.mem_q[3][`DATA_WIDTH];
    op(1'b1, 1'b0, 1'b1, 1'b0, 12'd3, 16'h0);
    chk("par_not_early", 32'(par_err), 32'h0);
    repeat (LAT) @(posedge clk);
    @(negedge clk);
    chk("par_pulse", 32'(par_err), 32'h1);
    chk("par_rdata", 32'(ram_if.R_data), 32'h0003);
    @(posedge clk);
    @(negedge clk);
    chk("par_pulse_end", 32'(par_err), 32'h0);
    op(1'b1, 1'b0, 1'b1, 1'b0, 12'd4, 16'h0);
    repeat (LAT) @(posedge clk);
    @(negedge clk);
    chk("par_clean", 32'(par_err), 32'h0);
    chk("par_clean_rdata", 32'(ram_if.R_data), 32'h1111);
`endif

    // Leave non-reset state visible, then reset mid-fill.
    op(1'b1, 1'b0, 1'b1, 1'b0, 12'd16, 16'h0);
    chk("pre_rst_err", 32'(addr_err), 32'h1);
    rst_n = 1'b0;
    #1;
    reset_checks("run_rst");
    @(negedge clk);
    rst_n = 1'b1;
    repeat (7) @(posedge clk);
    @(negedge clk);
    chk("mid_init_ready", 32'(ready), 32'h0);
    rst_n = 1'b0;
    #1;
    reset_checks("mid_rst");
    @(negedge clk);
    fill("refill", 1'b1);
    op(1'b1, 1'b0, 1'b1, 1'b0, 12'd3, 16'h0);
    wait_lat();
    chk("refill_zero", 32'(ram_if.R_data), 32'h0);
    op(1'b1, 1'b0, 1'b1, 1'b0, 12'd4, 16'h0);
    wait_lat();
    chk("refill_zero4", 32'(ram_if.R_data), 32'h0);

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/sp_ram_responder.md
Name: sp_ram_responder

Overview:
- Memory-side responder for the single-port RAM interface; connects to the `memory` modport and serves cs/oe/addr/W_req/W_data requests from a compute unit.
- Holds a DEPTH-word synchronous storage array, zero-fills it after reset, and returns read data with a fixed, parameterised latency.
- Reports illegal addresses through a sticky error flag.
- Used as the on-chip weight/activation buffer behind each compute engine.

Parameters:
- DEPTH, 1024, number of words; must be ≤ 2**`ADDR_WIDTH.
- READ_LAT, 1, cycles from request sample to R_data update; legal values 1 or 2, any other value is an elaboration error.

Ports:
- clk  input  1  system clock, all state updates on rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- mem  modport  -  single_port_ram_intf.memory: inputs cs, oe, addr[`ADDR_WIDTH], W_req, W_data[`DATA_WIDTH]; output R_data[`DATA_WIDTH].
- ready  output  1  high once zero-fill has completed; requests are honoured only while high.
- addr_err  output  1  sticky flag, set by any request with addr ≥ DEPTH.
- err_clr  input  1  clears addr_err.
- par_err  output  1  one-cycle parity-error pulse (see Optional Feature).

Behaviour:
- Reset values: R_data=0, ready=0, addr_err=0, par_err=0, FSM=INIT, init counter=0, read pipeline valid bits=0.
- FSM INIT:
  - Writes 0 to word init_cnt each cycle; init_cnt increments.
  - At init_cnt==DEPTH-1, writes that word and moves to RUN. INIT lasts exactly DEPTH cycles after reset release.
  - All requests are ignored in INIT: no write, no read issue, no addr_err.
- FSM RUN:
  - ready=1; the FSM stays in RUN until reset.
  - A reset assertion at any time (including mid-INIT) returns to INIT with init_cnt=0 and the full fill restarts.
- Request sample (RUN, rising edge, cs=1):
  - W_req=1 (write): mem[addr] <= W_data. No read is issued and R_data is unchanged. oe is ignored.
  - W_req=0 (read): issues a read of mem[addr]; oe is captured with it.
  - cs=0: no action; R_data holds.
- Read return:
  - READ_LAT=1: R_data updates at the edge after sampling.
  - READ_LAT=2: R_data updates one edge later.
  - R_data loads only if the captured oe was 1; if oe was 0 the read completes silently and R_data holds.
  - Back-to-back reads pipeline at one per cycle.
- Ordering: a read sampled the cycle after a write to the same address returns the new data; the array is updated at the write edge.
- Out of range (addr ≥ DEPTH, RUN, cs=1):
  - A write is dropped.
  - A read returns 0 (subject to oe).
  - addr_err <= 1 at that edge.
- addr_err: err_clr=1 clears it next edge. A simultaneous new error and err_clr leaves addr_err=1 (set wins).
- No flow control: the requester must not assume back-pressure; requests presented while ready=0 are lost.

Optional Feature:
- Macro: RAM_PARITY_EN.
- Defined:
  - The array is widened by 1 bit, storing even parity of W_data on every write and 0 during INIT.
  - On each read return, recomputed parity is compared with the stored bit; a mismatch pulses par_err=1 for the cycle R_data updates.
  - The pulse fires even if oe=0.
  - Out-of-range reads never flag.
- Undefined: no parity storage; par_err is tied to 0. The port stays present so integration is unchanged.

Decomposition:
- Package sp_ram_pkg:
  - FSM enum (INIT, RUN).
  - READ_LAT legality constants.
  - Parity helper function (even parity of a `DATA_WIDTH word).
- Sub-module sp_ram_array:
  - Storage plus one-cycle synchronous read port and write port.
  - Width is `DATA_WIDTH, or `DATA_WIDTH+1 with RAM_PARITY_EN.
- sp_ram_responder contains the FSM, init counter, request decode, latency pipeline, error flags.

Test Plan:
- Reset release, DEPTH=16 -> ready rises exactly 16 cycles after rst_n high; afterwards, a read of every address with oe=1 returns 0.
- Write 0xA5A5 to addr 3, next cycle read addr 3 with oe=1 -> READ_LAT=1: R_data=0xA5A5 one edge after sample; READ_LAT=2: two edges.
- Read addr 3 with oe=0, then read addr 4 (holding 0x1111) with oe=1 -> R_data stays 0xA5A5 for the first read, then becomes 0x1111.
- Write 0xFFFF and read, each with addr=DEPTH -> no array change, read returns 0, addr_err=1; err_clr pulse -> addr_err=0; err_clr concurrent with another bad access -> addr_err stays 1.
- Assert rst_n=0 mid-INIT at init_cnt=7 -> all outputs return to reset values, full DEPTH-cycle fill restarts; requests during INIT are ignored, no addr_err.
- RAM_PARITY_EN: write 0x0003, force-flip the stored parity bit, read -> par_err pulses for 1 cycle aligned with the R_data update; an unmodified word gives par_err=0.
